// File: rtl/fifo_fwft_prog_pkg.sv
// Shared FIFO helpers: depth/width derivation and threshold legality checks
// used at elaboration time by the FIFO and its RAM.
package fifo_fwft_prog_pkg;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_bits(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int count_bits(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit afull_thresh_ok(input int addr_width, input int thresh);
    return (thresh >= 1) && (thresh <= fifo_depth(addr_width));
  endfunction

  function automatic bit aempty_thresh_ok(input int addr_width, input int thresh);
    return (thresh >= 0) && (thresh <= fifo_depth(addr_width) - 1);
  endfunction

endpackage

// File: rtl/fifo_fwft_prog_dpram.sv
// Single-clock simple dual-port RAM, one write port and one registered read port.
// Read-during-write to the same address returns the old contents.
module simple_dpram_sclk
  import fifo_fwft_prog_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_reg [0:fifo_depth(ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[wr_addr] <= wr_data;
    end
    rd_data <= mem_reg[rd_addr];
  end

endmodule

// File: rtl/fifo_fwft_prog.sv
// First-word-fall-through FIFO with occupancy, programmable almost flags,
// sticky overflow/underflow and synchronous flush.
module fifo_fwft_prog
  import fifo_fwft_prog_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic                            wr_en,
  output logic                            full,
  output logic                            almost_full,
  output logic [DATA_WIDTH-1:0]           dout,
  input  logic                            rd_en,
  output logic                            empty,
  output logic                            almost_empty,
  output logic [count_bits(ADDR_WIDTH)-1:0] count,
  input  logic                            flush,
  output logic                            overflow,
  output logic                            underflow,
  input  logic                            clr_err
);

  localparam int PW = ptr_bits(ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRESH);

  if (ADDR_WIDTH < 1) begin : g_bad_addr_width
    $error("fifo_fwft_prog: ADDR_WIDTH must be >= 1");
  end
  if (!afull_thresh_ok(ADDR_WIDTH, AFULL_THRESH)) begin : g_bad_afull
    $error("fifo_fwft_prog: AFULL_THRESH out of range 1..DEPTH");
  end
  if (!aempty_thresh_ok(ADDR_WIDTH, AEMPTY_THRESH)) begin : g_bad_aempty
    $error("fifo_fwft_prog: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic                  wr_accept, rd_accept, bypass;
  logic                  byp_valid_reg;
  logic [DATA_WIDTH-1:0] byp_data_reg, ram_q;
  logic                  overflow_reg, underflow_reg;

  // Flags are pure functions of the registered pointers.
  assign count        = wr_ptr_reg - rd_ptr_reg;
  assign empty        = (wr_ptr_reg == rd_ptr_reg);
  assign full         = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                        (wr_ptr_reg[PW-2:0] == rd_ptr_reg[PW-2:0]);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  assign wr_accept   = wr_en && !full && !flush;
  assign rd_accept   = rd_en && !empty && !flush;
  assign wr_ptr_next = flush ? '0 : wr_ptr_reg + PW'(wr_accept);
  assign rd_ptr_next = flush ? '0 : rd_ptr_reg + PW'(rd_accept);

  // The RAM cannot return a word written on the same edge, so a write that
  // lands on the next head address is captured directly.
  assign bypass = wr_accept && (wr_ptr_reg == rd_ptr_next);
  assign dout   = byp_valid_reg ? byp_data_reg : ram_q;

  simple_dpram_sclk #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we     (wr_accept),
    .wr_addr(wr_ptr_reg[PW-2:0]),
    .wr_data(din),
    .rd_addr(rd_ptr_next[PW-2:0]),
    .rd_data(ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      byp_valid_reg <= 1'b1;
      byp_data_reg  <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (bypass) begin
        byp_valid_reg <= 1'b1;
        byp_data_reg  <= din;
      end else if (wr_accept || rd_accept || flush) begin
        byp_valid_reg <= 1'b0;
      end
      if (wr_en && full && !flush) begin
        overflow_reg <= 1'b1;
      end else if (clr_err) begin
        overflow_reg <= 1'b0;
      end
      if (rd_en && empty && !flush) begin
        underflow_reg <= 1'b1;
      end else if (clr_err) begin
        underflow_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_fwft_prog.sv
// Scenario bench for fifo_fwft_prog against a queue-based reference model.
module tb_fifo_fwft_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic       full, almost_full, empty, almost_empty, overflow, underflow;
  logic [7:0] dout;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  fifo_fwft_prog #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(full),
    .almost_full(almost_full), .dout(dout), .rd_en(rd_en), .empty(empty),
    .almost_empty(almost_empty), .count(count), .flush(flush),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Applies one cycle of stimulus and advances the reference model.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r,
                       input logic f, input logic c);
    bit m_full, m_empty;
    wr_en = w; din = d; rd_en = r; flush = f; clr_err = c;
    m_full  = (mq.size() == 16);
    m_empty = (mq.size() == 0);
    if (f) begin
      mq.delete();
    end else begin
      if (r && !m_empty) void'(mq.pop_front());
      if (w && !m_full) mq.push_back(d);
    end
    m_ovf = (w && m_full && !f) ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf = (r && m_empty && !f) ? 1'b1 : (c ? 1'b0 : m_unf);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    $display("txn t=%0t wr=%b din=%h rd=%b fl=%b clr=%b -> count=%0d empty=%b dout=%h ovf=%b unf=%b",
             $time, w, d, r, f, c, count, empty, dout, overflow, underflow);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (empty !== 1'b1 || count !== 5'd0 || full !== 1'b0 || almost_full !== 1'b0) begin
      errors++; $display("FAIL reset_init_level got empty=%b count=%0d full=%b af=%b exp 1/0/0/0", empty, count, full, almost_full); end
    checks++; if (almost_empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || dout !== 8'h00) begin
      errors++; $display("FAIL reset_init_flags got ae=%b ovf=%b unf=%b dout=%h exp 1/0/0/00", almost_empty, overflow, underflow, dout); end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (underflow !== 1'b1) begin
      errors++; $display("FAIL reset_pre_underflow got %b exp 1", underflow); end
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 5'd3) begin
      errors++; $display("FAIL reset_pre_count got %0d exp 3", count); end
    // Reset lands mid-cycle during the fourth write of the burst.
    wr_en = 1'b1; din = 8'h13;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || count !== 5'd0 || almost_empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_async_level got empty=%b count=%0d ae=%b full=%b exp 1/0/1/0", empty, count, almost_empty, full); end
    checks++; if (almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || dout !== 8'h00) begin
      errors++; $display("FAIL reset_async_flags got af=%b ovf=%b unf=%b dout=%h exp 0/0/0/00", almost_full, overflow, underflow, dout); end
    wr_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (count !== 5'd0) begin
      errors++; $display("FAIL reset_hold_count got %0d exp 0", count); end
    #2 rst_n = 1'b1;
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fwft();
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    checks++; if (empty !== 1'b0 || dout !== 8'hA5 || count !== 5'd1) begin
      errors++; $display("FAIL fwft_first got empty=%b dout=%h count=%0d exp 0/a5/1", empty, dout, count); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (empty !== 1'b1 || count !== 5'd0 || underflow !== 1'b0) begin
      errors++; $display("FAIL fwft_pop got empty=%b count=%0d unf=%b exp 1/0/0", empty, count, underflow); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      checks++; if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 12) || full !== (i + 1 == 16) || almost_empty !== (i + 1 <= 2)) begin
        errors++; $display("FAIL fill_level_%0d got count=%0d af=%b full=%b ae=%b exp %0d/%b/%b/%b",
                           i, count, almost_full, full, almost_empty, i + 1, i + 1 >= 12, i + 1 == 16, i + 1 <= 2); end
    end
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      errors++; $display("FAIL fill_overflow got ovf=%b count=%0d full=%b exp 1/16/1", overflow, count, full); end
    // Write while full with a concurrent read must still be rejected.
    cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1 || count !== 5'd15 || dout !== 8'h01) begin
      errors++; $display("FAIL fill_full_rdwr got ovf=%b count=%0d dout=%h exp 1/15/01", overflow, count, dout); end
    for (int i = 1; i < 16; i++) begin
      checks++; if (dout !== 8'(i) || empty !== 1'b0) begin
        errors++; $display("FAIL drain_data_%0d got dout=%h empty=%b exp %h/0", i, dout, empty, 8'(i)); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL drain_end got empty=%b ovf=%b exp 1/1", empty, overflow); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin
      errors++; $display("FAIL fill_clr_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_wrap_concurrent();
    logic [7:0] exp_head = 8'h40;
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 40; j++) begin
      checks++; if (dout !== exp_head) begin
        errors++; $display("FAIL wrap_head_%0d got %h exp %h", j, dout, exp_head); end
      cycle(1'b1, 8'(8'h48 + j), 1'b1, 1'b0, 1'b0);
      exp_head = exp_head + 8'd1;
      checks++; if (count !== 5'd8) begin
        errors++; $display("FAIL wrap_count_%0d got %0d exp 8", j, count); end
    end
  endtask

  task automatic test_underflow_clear();
    while (mq.size() > 0) begin
      checks++; if (dout !== mq[0]) begin
        errors++; $display("FAIL uf_drain got %h exp %h", dout, mq[0]); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (underflow !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL uf_before got unf=%b empty=%b exp 0/1", underflow, empty); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (underflow !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL uf_set got unf=%b count=%0d exp 1/0", underflow, count); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++; if (underflow !== 1'b1) begin
      errors++; $display("FAIL uf_set_wins got %b exp 1", underflow); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL uf_clear got unf=%b ovf=%b exp 0/0", underflow, overflow); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 5'd6 || overflow !== 1'b1 || dout !== 8'h8A) begin
      errors++; $display("FAIL flush_pre got count=%0d ovf=%b dout=%h exp 6/1/8a", count, overflow, dout); end
    cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    checks++; if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b1 || underflow !== 1'b0) begin
      errors++; $display("FAIL flush_clear got count=%0d empty=%b ovf=%b unf=%b exp 0/1/1/0", count, empty, overflow, underflow); end
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checks++; if (underflow !== 1'b0) begin
      errors++; $display("FAIL flush_rd_empty got unf=%b exp 0", underflow); end
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    checks++; if (dout !== 8'h3C || empty !== 1'b0 || count !== 5'd1) begin
      errors++; $display("FAIL flush_next_write got dout=%h empty=%b count=%0d exp 3c/0/1", dout, empty, count); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 19) == 0));
      checks++; if (count !== 5'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == 16)) begin
        errors++; $display("FAIL rand_level_%0d got count=%0d empty=%b full=%b exp %0d", n, count, empty, full, mq.size()); end
      checks++; if (almost_full !== (mq.size() >= 12) || almost_empty !== (mq.size() <= 2)) begin
        errors++; $display("FAIL rand_almost_%0d got af=%b ae=%b for level %0d", n, almost_full, almost_empty, mq.size()); end
      checks++; if (overflow !== m_ovf || underflow !== m_unf) begin
        errors++; $display("FAIL rand_sticky_%0d got ovf=%b unf=%b exp %b/%b", n, overflow, underflow, m_ovf, m_unf); end
      if (mq.size() > 0) begin
        checks++; if (dout !== mq[0]) begin
          errors++; $display("FAIL rand_dout_%0d got %h exp %h", n, dout, mq[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwft();
    test_fill();
    test_wrap_concurrent();
    test_underflow_clear();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
